paint_cmd_scheduler: RTL and testbench

Executes the decoded HID command stream against the framebuffer write port. The block sits between the Bluetooth decoder outputs (cmd/x/y plus a one-cycle valid pulse) and the framebuffer. It buffers commands in a small FIFO so bursts are not lost while a write is stalled. It holds the cursor and pen-colour state, and turns each command into zero, one or 4096 framebuffer write transactions.

---
 rtl/hid_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 55 +++++
 rtl/paint_cmd_scheduler.sv | 150 +++++++++++++++
 tb/tb_paint_cmd_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// Shared definitions for the HID command path: command codes, operand widths
// and framebuffer geometry, imported by the decoder and the paint scheduler.
package hid_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_MOVE      = 3'd1;
  localparam logic [2:0] CMD_DRAW      = 3'd2;
  localparam logic [2:0] CMD_ERASE     = 3'd3;
  localparam logic [2:0] CMD_SET_COLOR = 3'd4;
  localparam logic [2:0] CMD_CLEAR     = 3'd5;
  localparam logic [2:0] CMD_FILL      = 3'd6;
  localparam logic [2:0] CMD_RSVD      = 3'd7;

  localparam int CMD_W     = 3;
  localparam int COORD_W   = 6;
  localparam int FB_ADDR_W = 12;
  localparam int FB_PIXELS = 4096;

  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through read data.
// A push while full is still taken when a pop lands in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/paint_cmd_scheduler.sv
// Executes queued HID commands against the framebuffer write port.
// state | meaning: IDLE pop/decode next command; WRITE single pixel until ack; FILL sweep 0..4095
module paint_cmd_scheduler
  import hid_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COLOR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CMD_W-1:0]     cmd_in,
  input  logic [COORD_W-1:0]   x_in,
  input  logic [COORD_W-1:0]   y_in,
  input  logic                 cmd_valid,
  output logic                 fb_req,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_wdata,
  input  logic                 fb_ack,
  output logic [COORD_W-1:0]   cursor_x,
  output logic [COORD_W-1:0]   cursor_y,
  output logic [COLOR_W-1:0]   pen_color,
  output logic                 busy,
  output logic                 overflow
);

  cmd_entry_t             push_entry;
  cmd_entry_t             head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_drop;
  logic                   pop;
  logic                   xfer;

  sched_state_e           state_q, state_d;
  logic [FB_ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOR_W-1:0]     wdata_q, wdata_d;
  logic [COLOR_W-1:0]     pen_q, pen_d;
  logic [COORD_W-1:0]     cur_x_q, cur_x_d;
  logic [COORD_W-1:0]     cur_y_q, cur_y_d;
  logic                   ovf_q;

  assign push_entry = '{cmd: cmd_in, x: x_in, y: y_in};
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign xfer       = fb_req && fb_ack;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // In FILL, addr_q doubles as the fill counter, so the address is the count.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pen_d   = pen_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          case (head.cmd)
            CMD_MOVE: begin
              cur_x_d = head.x;
              cur_y_d = head.y;
            end
            CMD_SET_COLOR: pen_d = head.x[COLOR_W-1:0];
            CMD_DRAW: begin
              cur_x_d = head.x;
              cur_y_d = head.y;
              addr_d  = {head.y, head.x};
              wdata_d = pen_q;
              state_d = ST_WRITE;
            end
            CMD_ERASE: begin
              addr_d  = {head.y, head.x};
              wdata_d = '0;
              state_d = ST_WRITE;
            end
            CMD_CLEAR: begin
              addr_d  = '0;
              wdata_d = '0;
              state_d = ST_FILL;
            end
            CMD_FILL: begin
              addr_d  = '0;
              wdata_d = pen_q;
              state_d = ST_FILL;
            end
            CMD_NOP, CMD_RSVD: ;
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        if (xfer) state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (xfer) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == FB_ADDR_W'(FB_PIXELS - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      pen_q   <= COLOR_W'(1);
      cur_x_q <= '0;
      cur_y_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pen_q   <= pen_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  assign fb_req    = (state_q != ST_IDLE);
  assign fb_addr   = addr_q;
  assign fb_wdata  = wdata_q;
  assign cursor_x  = cur_x_q;
  assign cursor_y  = cur_y_q;
  assign pen_color = pen_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign overflow  = ovf_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_paint_cmd_scheduler.sv
// Directed bench for paint_cmd_scheduler: a command-level model predicts the
// framebuffer write stream, cursor and pen; a negedge monitor checks each write.
module tb_paint_cmd_scheduler;
  import hid_pkg::*;

  localparam int DEPTH   = 4;
  localparam int COLOR_W = 3;

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b0;
  logic [2:0]         cmd_in    = '0;
  logic [5:0]         x_in      = '0;
  logic [5:0]         y_in      = '0;
  logic               cmd_valid = 1'b0;
  logic               fb_ack    = 1'b0;
  logic               fb_req;
  logic [11:0]        fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic [5:0]         cursor_x;
  logic [5:0]         cursor_y;
  logic [COLOR_W-1:0] pen_color;
  logic               busy;
  logic               overflow;

  paint_cmd_scheduler #(.DEPTH(DEPTH), .COLOR_W(COLOR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_in    (cmd_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .cmd_valid (cmd_valid),
    .fb_req    (fb_req),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_ack    (fb_ack),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .pen_color (pen_color),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [11:0]        addr;
    logic [COLOR_W-1:0] data;
  } wr_t;

  wr_t                exp_q[$];
  int                 m_cx, m_cy, m_pen;
  int                 checks = 0;
  int                 passes = 0;
  int                 ack_mode = 0;
  int                 ack_wait = 0;
  bit                 mon_en = 1'b0;
  logic [11:0]        obs_addr[$];
  logic [COLOR_W-1:0] obs_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_cx  = 0;
    m_cy  = 0;
    m_pen = 1;
  endfunction

  function automatic void model_cmd(input int c, input int x, input int y);
    case (c)
      1: begin m_cx = x; m_cy = y; end
      2: begin
        m_cx = x; m_cy = y;
        exp_q.push_back('{addr: 12'(y * 64 + x), data: COLOR_W'(m_pen)});
      end
      3: exp_q.push_back('{addr: 12'(y * 64 + x), data: '0});
      4: m_pen = x % (1 << COLOR_W);
      5: for (int i = 0; i < 4096; i++) exp_q.push_back('{addr: 12'(i), data: '0});
      6: for (int i = 0; i < 4096; i++) exp_q.push_back('{addr: 12'(i), data: COLOR_W'(m_pen)});
      default: ;
    endcase
  endfunction

  // ack_mode: 0 low, 1 high, 2 toggle, 3 ack after 3 waiting cycles, 4 manual
  always @(posedge clk) begin
    #2;
    case (ack_mode)
      0: fb_ack = 1'b0;
      1: fb_ack = 1'b1;
      2: fb_ack = ~fb_ack;
      3: begin
        if (fb_req && !fb_ack) ack_wait++;
        else ack_wait = 0;
        fb_ack = (ack_wait >= 3);
      end
      default: ;
    endcase
  end

  logic               prev_wait = 1'b0;
  logic [11:0]        prev_addr = '0;
  logic [COLOR_W-1:0] prev_data = '0;
  wr_t                mon_e;

  always @(negedge clk) begin
    if (!mon_en || !reset_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait)
        check("hold_req_addr_data", {fb_req, fb_addr, fb_wdata}, {1'b1, prev_addr, prev_data});
      if (fb_req && fb_ack) begin
        obs_addr.push_back(fb_addr);
        obs_data.push_back(fb_wdata);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_write: addr 0x%0h data %0d, no write expected", fb_addr, fb_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", fb_addr, mon_e.addr);
          check("write_data", fb_wdata, mon_e.data);
        end
      end
      prev_wait = fb_req && !fb_ack;
      prev_addr = fb_addr;
      prev_data = fb_wdata;
    end
  end

  task automatic send(input int c, input int x, input int y, input bit dropped);
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_in    = 3'(c);
    x_in      = 6'(x);
    y_in      = 6'(y);
    if (!dropped) model_cmd(c, x, y);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check({name, "_idle"}, busy, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    mon_en    = 1'b0;
    cmd_valid = 1'b0;
    reset_n   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic check_state(input string name);
    check({name, "_cursor_x"}, cursor_x, m_cx);
    check({name, "_cursor_y"}, cursor_y, m_cy);
    check({name, "_pen"}, pen_color, m_pen);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // reset values
    @(negedge clk);
    check("rst_fb_req", fb_req, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_wdata", fb_wdata, 0);
    check("rst_cursor", {cursor_y, cursor_x}, 0);
    check("rst_pen", pen_color, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // DRAW (5,9) with ack tied high: one-cycle request two cycles after the pulse
    ack_mode = 1;
    send(CMD_DRAW, 5, 9, 1'b0);
    @(negedge clk);
    check("draw_req_n1", fb_req, 0);
    @(negedge clk);
    check("draw_req_n2", fb_req, 1);
    check("draw_addr", fb_addr, 12'h245);
    check("draw_wdata", fb_wdata, 1);
    @(negedge clk);
    check("draw_req_n3", fb_req, 0);
    check("draw_cursor_x", cursor_x, 5);
    check("draw_cursor_y", cursor_y, 9);
    check("draw_pending", exp_q.size(), 0);

    // SET_COLOR 6, ERASE (3,3), DRAW (3,3) with delayed acks
    ack_mode = 3;
    obs_addr.delete(); obs_data.delete();
    send(CMD_SET_COLOR, 6, 0, 1'b0);
    send(CMD_ERASE, 3, 3, 1'b0);
    send(CMD_DRAW, 3, 3, 1'b0);
    wait_idle("erase_draw", 200);
    check("erase_draw_count", obs_addr.size(), 2);
    if (obs_addr.size() >= 2) begin
      check("erase_addr", obs_addr[0], 12'h0C3);
      check("erase_data", obs_data[0], 0);
      check("draw2_addr", obs_addr[1], 12'h0C3);
      check("draw2_data", obs_data[1], 6);
    end
    check_state("erase_draw");

    // SET_COLOR 2, FILL with ack toggling every cycle
    ack_mode = 2;
    obs_addr.delete(); obs_data.delete();
    send(CMD_SET_COLOR, 2, 0, 1'b0);
    send(CMD_FILL, 0, 0, 1'b0);
    wait_idle("fill", 10000);
    check("fill_count", obs_addr.size(), 4096);
    if (obs_addr.size() == 4096) begin
      check("fill_last_addr", obs_addr[4095], 4095);
      check("fill_last_data", obs_data[4095], 2);
    end
    check_state("fill");

    // CLEAR stalled, then 5 pulses into a 4-entry FIFO
    ack_mode = 0;
    obs_addr.delete(); obs_data.delete();
    send(CMD_CLEAR, 0, 0, 1'b0);
    send(CMD_MOVE, 1, 2, 1'b0);
    send(CMD_SET_COLOR, 5, 0, 1'b0);
    send(CMD_DRAW, 7, 8, 1'b0);
    send(CMD_ERASE, 10, 11, 1'b0);
    send(CMD_MOVE, 20, 21, 1'b1);
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_busy", busy, 1);
    check("ovf_stalled_addr", fb_addr, 0);
    ack_mode = 1;
    wait_idle("clear", 6000);
    check("clear_count", obs_addr.size(), 4098);
    if (obs_addr.size() == 4098) begin
      check("clear_draw_addr", obs_addr[4096], 12'h207);
      check("clear_draw_data", obs_data[4096], 5);
      check("clear_erase_addr", obs_addr[4097], 12'h2CA);
    end
    check("clear_cursor", {cursor_y, cursor_x}, {6'd8, 6'd7});
    check_state("clear");
    check("ovf_sticky", overflow, 1);

    // push into a full FIFO in the same cycle as a pop
    do_reset();
    ack_mode = 4;
    fb_ack   = 1'b0;
    obs_addr.delete(); obs_data.delete();
    @(negedge clk);
    check("rst2_overflow", overflow, 0);
    send(CMD_DRAW, 1, 1, 1'b0);
    send(CMD_MOVE, 2, 2, 1'b0);
    send(CMD_MOVE, 3, 3, 1'b0);
    send(CMD_MOVE, 4, 4, 1'b0);
    send(CMD_MOVE, 5, 5, 1'b0);
    @(negedge clk);
    check("full_no_ovf", overflow, 0);
    @(posedge clk); #2;
    fb_ack = 1'b1;
    @(posedge clk); #2;
    fb_ack    = 1'b0;
    cmd_valid = 1'b1;
    cmd_in    = CMD_MOVE;
    x_in      = 6'd6;
    y_in      = 6'd6;
    model_cmd(1, 6, 6);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    wait_idle("pushpop", 100);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_cursor", {cursor_y, cursor_x}, {6'd6, 6'd6});
    check("pushpop_writes", obs_addr.size(), 1);
    if (obs_addr.size() == 1) check("pushpop_addr", obs_addr[0], 12'h041);

    // reset in the middle of a fill
    do_reset();
    ack_mode = 1;
    send(CMD_SET_COLOR, 3, 0, 1'b0);
    send(CMD_FILL, 0, 0, 1'b0);
    send(CMD_MOVE, 9, 9, 1'b0);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (fb_addr == 12'd100) break;
    end
    check("midfill_at_100", fb_addr, 100);
    #3;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_req", fb_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", fb_addr, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_req", fb_req, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_ovf", overflow, 0);
    check("post_rst_cursor", {cursor_y, cursor_x}, 0);
    check("post_rst_pen", pen_color, 1);
    check_state("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
